// File: rtl/pll_enable_sequencer.sv
// PLL enable sequencer: delays PLL_EN after start, waits for a synchronized stable lock,
// retries with an enable back-off on lock timeout, and reports clk_ready only while locked.
module pll_enable_sequencer #(
    parameter int unsigned STARTUP_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 1024,
    parameter int unsigned LOCK_STABLE    = 8,
    parameter int unsigned OFF_CYCLES     = 8,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned SYNC_STAGES    = 2,
    localparam int unsigned RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               pll_lock,
    output logic               pll_en,
    output logic               clk_ready,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [2:0]         state
);

    localparam int unsigned CNT_MAX_A = (STARTUP_CYCLES > OFF_CYCLES) ? STARTUP_CYCLES : OFF_CYCLES;
    localparam int unsigned CNT_MAX   = (LOCK_TIMEOUT > CNT_MAX_A) ? LOCK_TIMEOUT : CNT_MAX_A;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam int unsigned STABLE_W  = $clog2(LOCK_STABLE + 1);

    localparam logic [CNT_W-1:0]    STARTUP_LAST = CNT_W'(STARTUP_CYCLES - 1);
    localparam logic [CNT_W-1:0]    TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]    OFF_LAST     = CNT_W'(OFF_CYCLES - 1);
    localparam logic [STABLE_W-1:0] STABLE_LAST  = STABLE_W'(LOCK_STABLE - 1);
    localparam logic [RETRY_W-1:0]  RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    if (STARTUP_CYCLES == 0 || LOCK_TIMEOUT == 0 || LOCK_STABLE == 0 ||
        OFF_CYCLES == 0 || MAX_RETRIES == 0 || SYNC_STAGES < 2) begin : g_bad_param
        $error("pll_enable_sequencer: parameters must be nonzero and SYNC_STAGES >= 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DELAY     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_LOCKED    = 3'd3,
        ST_BACKOFF   = 3'd4,
        ST_FAIL      = 3'd5
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [STABLE_W-1:0]    stable_q, stable_d;
    logic [RETRY_W-1:0]     retry_q, retry_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pll_en_q, clk_ready_q, fail_q;
    logic                   lock_s;

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        retry_d  = retry_q;

        if (stop) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            stable_d = '0;
        end else if (start && (state_q == ST_IDLE || state_q == ST_FAIL)) begin
            state_d  = ST_DELAY;
            cnt_d    = '0;
            stable_d = '0;
            retry_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_DELAY: begin
                    if (cnt_q == STARTUP_LAST) begin
                        state_d  = ST_WAIT_LOCK;
                        cnt_d    = '0;
                        stable_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    stable_d = lock_s ? stable_q + STABLE_W'(1) : '0;
                    // A completed lock takes precedence over a timeout on the same cycle.
                    if (lock_s && stable_q == STABLE_LAST) begin
                        state_d  = ST_LOCKED;
                        cnt_d    = '0;
                        stable_d = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        cnt_d    = '0;
                        stable_d = '0;
                        if (retry_q == RETRY_MAX) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d = ST_BACKOFF;
                            retry_d = retry_q + RETRY_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (!lock_s) begin
                        state_d = ST_BACKOFF;
                        cnt_d   = '0;
                        retry_d = '0;
                    end
                end
                ST_BACKOFF: begin
                    if (cnt_q == OFF_LAST) begin
                        state_d  = ST_WAIT_LOCK;
                        cnt_d    = '0;
                        stable_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_FAIL: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            stable_q    <= '0;
            retry_q     <= '0;
            sync_q      <= '0;
            pll_en_q    <= 1'b0;
            clk_ready_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stable_q    <= stable_d;
            retry_q     <= retry_d;
            sync_q      <= {sync_q[SYNC_STAGES-2:0], pll_lock};
            // Outputs decode the next state so they switch on the same edge as the FSM.
            pll_en_q    <= (state_d == ST_WAIT_LOCK) || (state_d == ST_LOCKED);
            clk_ready_q <= (state_d == ST_LOCKED);
            fail_q      <= (state_d == ST_FAIL);
        end
    end

    assign pll_en    = pll_en_q;
    assign clk_ready = clk_ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pll_enable_sequencer.sv
// Scoreboarded bench for pll_enable_sequencer: a phase/elapsed-time reference model pushes the
// expected outputs for every edge, and a negedge monitor pops and compares them.
module tb_pll_enable_sequencer;

    localparam int unsigned P_STARTUP = 4;
    localparam int unsigned P_TIMEOUT = 16;
    localparam int unsigned P_STABLE  = 4;
    localparam int unsigned P_OFF     = 4;
    localparam int unsigned P_RETRIES = 2;
    localparam int unsigned P_SYNC    = 2;
    localparam int RW = $clog2(P_RETRIES + 1);

    localparam int S_IDLE = 0, S_DELAY = 1, S_WAIT = 2, S_LOCKED = 3, S_BACKOFF = 4, S_FAIL = 5;

    logic          clk, rst, start, stop, pll_lock;
    logic          pll_en, clk_ready, fail;
    logic [RW-1:0] retry_cnt;
    logic [2:0]    state;

    pll_enable_sequencer #(
        .STARTUP_CYCLES(P_STARTUP),
        .LOCK_TIMEOUT  (P_TIMEOUT),
        .LOCK_STABLE   (P_STABLE),
        .OFF_CYCLES    (P_OFF),
        .MAX_RETRIES   (P_RETRIES),
        .SYNC_STAGES   (P_SYNC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .pll_lock (pll_lock),
        .pll_en   (pll_en),
        .clk_ready(clk_ready),
        .fail     (fail),
        .retry_cnt(retry_cnt),
        .state    (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int st;
        int en;
        int rdy;
        int fl;
        int rc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   en_rises = 0;
    int   rdy_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: phase, cycles spent in the phase, consecutive-lock run, retries used.
    int m_phase = S_IDLE;
    int m_elapsed = 0;
    int m_run = 0;
    int m_retries = 0;
    bit m_hist[$];

    task automatic model_reset_sync();
        m_hist.delete();
        for (int i = 0; i < int'(P_SYNC); i++) m_hist.push_back(1'b0);
    endtask

    task automatic model_enter(input int phase);
        m_phase   = phase;
        m_elapsed = 0;
        m_run     = 0;
    endtask

    task automatic model_step();
        bit   lock_seen;
        exp_t e;
        lock_seen = m_hist.pop_front();
        m_hist.push_back(pll_lock);
        if (rst) begin
            model_reset_sync();
            model_enter(S_IDLE);
            m_retries = 0;
        end else if (stop) begin
            model_enter(S_IDLE);
        end else if (start && (m_phase == S_IDLE || m_phase == S_FAIL)) begin
            model_enter(S_DELAY);
            m_retries = 0;
        end else begin
            case (m_phase)
                S_DELAY: begin
                    m_elapsed++;
                    if (m_elapsed == int'(P_STARTUP)) model_enter(S_WAIT);
                end
                S_WAIT: begin
                    m_elapsed++;
                    m_run = lock_seen ? m_run + 1 : 0;
                    if (m_run == int'(P_STABLE)) begin
                        model_enter(S_LOCKED);
                    end else if (m_elapsed == int'(P_TIMEOUT)) begin
                        if (m_retries == int'(P_RETRIES)) begin
                            model_enter(S_FAIL);
                        end else begin
                            m_retries++;
                            model_enter(S_BACKOFF);
                        end
                    end
                end
                S_LOCKED: begin
                    if (!lock_seen) begin
                        m_retries = 0;
                        model_enter(S_BACKOFF);
                    end
                end
                S_BACKOFF: begin
                    m_elapsed++;
                    if (m_elapsed == int'(P_OFF)) model_enter(S_WAIT);
                end
                default: ;
            endcase
        end
        e.st  = m_phase;
        e.en  = (m_phase == S_WAIT || m_phase == S_LOCKED) ? 1 : 0;
        e.rdy = (m_phase == S_LOCKED) ? 1 : 0;
        e.fl  = (m_phase == S_FAIL) ? 1 : 0;
        e.rc  = m_retries;
        exp_q.push_back(e);
    endtask

    initial begin
        model_reset_sync();
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: compare the DUT against each expected entry half a cycle after its edge.
    initial begin
        exp_t e;
        logic prev_en;
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("state",     32'(state),     e.st);
                check("pll_en",    32'(pll_en),    e.en);
                check("clk_ready", 32'(clk_ready), e.rdy);
                check("fail",      32'(fail),      e.fl);
                check("retry_cnt", 32'(retry_cnt), e.rc);
                if (pll_en === 1'b1 && prev_en === 1'b0) en_rises++;
                if (clk_ready === 1'b1) rdy_cycles++;
                prev_en = pll_en;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
    endtask

    initial begin
        int base_en;
        int base_rdy;
        rst = 1'b1; start = 1'b0; stop = 1'b0; pll_lock = 1'b1;
        cyc(3);
        rst = 1'b0;

        // Clean lock with pll_lock held high.
        pulse_start();
        cyc(20);

        // One-cycle lock drop while LOCKED: back-off, then relock with a fresh retry budget.
        pll_lock = 1'b0;
        cyc(1);
        pll_lock = 1'b1;
        cyc(20);

        // stop while LOCKED.
        pulse_stop();
        cyc(3);

        // Lock never arrives: retries exhausted, FAIL held for 100+ cycles.
        pll_lock = 1'b0;
        base_en = en_rises;
        pulse_start();
        cyc(170);
        check("attempts_before_fail", 32'(en_rises - base_en), P_RETRIES + 1);

        // start from FAIL, then stop in the middle of WAIT_LOCK.
        pulse_start();
        cyc(10);
        pulse_stop();
        cyc(3);

        // Lock glitching 1,1,1,0 never satisfies the stable window.
        base_en  = en_rises;
        base_rdy = rdy_cycles;
        pulse_start();
        for (int i = 0; i < 170; i++) begin
            pll_lock = (i % 4 != 3);
            cyc(1);
        end
        check("glitch_attempts", 32'(en_rises - base_en), P_RETRIES + 1);
        check("glitch_ready_cycles", 32'(rdy_cycles - base_rdy), 0);

        // Reset pulse during BACKOFF with start held high, then a clean restart.
        pll_lock = 1'b0;
        pulse_start();
        cyc(21);
        start = 1'b1;
        rst   = 1'b1;
        cyc(1);
        rst   = 1'b0;
        cyc(1);
        start = 1'b0;
        pll_lock = 1'b1;
        cyc(30);

        // Randomized traffic: slowly toggling lock plus sparse start/stop/reset.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(7) == 0) pll_lock = ~pll_lock;
            start = ($urandom_range(19) == 0);
            stop  = ($urandom_range(63) == 0);
            rst   = ($urandom_range(299) == 0);
            cyc(1);
        end
        rst = 1'b0; start = 1'b0; stop = 1'b0;
        cyc(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
